// File: rtl/race_pkg.sv
// Shared definitions for the LED racer screen sequencer.
//   state_t       : screen states (MENU, PLAYING, WIN)
//   PLAYER_*      : 2-bit player identifiers used on winner_id
//   pos_width()   : bit width of a player position for a given track length
package race_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        WIN     = 2'd2
    } state_t;

    localparam logic [1:0] PLAYER_GREEN  = 2'd0;
    localparam logic [1:0] PLAYER_RED    = 2'd1;
    localparam logic [1:0] PLAYER_BLUE   = 2'd2;
    localparam logic [1:0] PLAYER_YELLOW = 2'd3;

    function automatic int pos_width(input int max_pos);
        return (max_pos > 1) ? $clog2(max_pos) : 1;
    endfunction

endpackage

// File: rtl/race_screen_controller_winner_select.sv
// Combinational winner priority encoder.
// Ports:
//   green_pos, red_pos, blue_pos, yellow_pos : player positions
//   winner_id : first player at the finish LED (MAX_POS-1) in order
//               green > red > blue > yellow; green if nobody is there
module winner_select
    import race_pkg::*;
#(
    parameter int MAX_POS = 109
) (
    input  logic [pos_width(MAX_POS)-1:0] green_pos,
    input  logic [pos_width(MAX_POS)-1:0] red_pos,
    input  logic [pos_width(MAX_POS)-1:0] blue_pos,
    input  logic [pos_width(MAX_POS)-1:0] yellow_pos,
    output logic [1:0]                    winner_id
);

    localparam int POS_W = pos_width(MAX_POS);
    localparam logic [POS_W-1:0] FINISH_POS = POS_W'(MAX_POS - 1);

    always_comb begin
        winner_id = PLAYER_GREEN;
        if (green_pos == FINISH_POS) begin
            winner_id = PLAYER_GREEN;
        end else if (red_pos == FINISH_POS) begin
            winner_id = PLAYER_RED;
        end else if (blue_pos == FINISH_POS) begin
            winner_id = PLAYER_BLUE;
        end else if (yellow_pos == FINISH_POS) begin
            winner_id = PLAYER_YELLOW;
        end
    end

endmodule

// File: rtl/race_screen_controller.sv
// Screen sequencer for the LED racer: MENU -> PLAYING -> WIN -> MENU.
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   start_btn         : debounced start button level
//   game_finished     : finish detector flag
//   *_cur_pos         : the four player positions
//   is_in_menu        : registered MENU indicator (feeds the finish detector)
//   players_reset     : one-cycle clear pulse for the position counters
//   winner_valid      : high while the win screen is shown
//   winner_id         : latched winner, meaningful when winner_valid=1
//   winner_blink      : blink phase for the winner LEDs, 0 outside WIN
//
// state   | meaning
// MENU    | waiting for a start button rising edge
// PLAYING | race running, waiting for game_finished
// WIN     | winner shown for WIN_HOLD_CYCLES cycles with blinking LEDs
module race_screen_controller
    import race_pkg::*;
#(
    parameter int MAX_POS         = 109,
    parameter int WIN_HOLD_CYCLES = 150000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_btn,
    input  logic                          game_finished,
    input  logic [pos_width(MAX_POS)-1:0] green_cur_pos,
    input  logic [pos_width(MAX_POS)-1:0] red_cur_pos,
    input  logic [pos_width(MAX_POS)-1:0] blue_cur_pos,
    input  logic [pos_width(MAX_POS)-1:0] yellow_cur_pos,
    output logic                          is_in_menu,
    output logic                          players_reset,
    output logic                          winner_valid,
    output logic [1:0]                    winner_id,
    output logic                          winner_blink
);

    localparam int HOLD_W  = (WIN_HOLD_CYCLES > 1) ? $clog2(WIN_HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WIN_HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    state_t              state_q, state_d;
    logic                start_btn_q;
    logic                in_menu_q, in_menu_d;
    logic                preset_q, preset_d;
    logic                valid_q, valid_d;
    logic [1:0]          id_q, id_d;
    logic                blink_q, blink_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic [1:0]          sel_id;
    logic                start_rise;

    winner_select #(
        .MAX_POS (MAX_POS)
    ) u_winner_select (
        .green_pos  (green_cur_pos),
        .red_pos    (red_cur_pos),
        .blue_pos   (blue_cur_pos),
        .yellow_pos (yellow_cur_pos),
        .winner_id  (sel_id)
    );

    assign start_rise = start_btn & ~start_btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MENU;
            start_btn_q <= 1'b0;
            in_menu_q   <= 1'b1;
            preset_q    <= 1'b0;
            valid_q     <= 1'b0;
            id_q        <= PLAYER_GREEN;
            blink_q     <= 1'b0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            start_btn_q <= start_btn;
            in_menu_q   <= in_menu_d;
            preset_q    <= preset_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            blink_q     <= blink_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        preset_d    = 1'b0;
        valid_d     = valid_q;
        id_d        = id_q;
        blink_d     = blink_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;

        case (state_q)
            MENU: begin
                if (start_rise) begin
                    state_d  = PLAYING;
                    preset_d = 1'b1;
                end
            end
            PLAYING: begin
                if (game_finished) begin
                    state_d     = WIN;
                    id_d        = sel_id;
                    valid_d     = 1'b1;
                    hold_d      = '0;
                    blink_cnt_d = '0;
                    blink_d     = 1'b1;
                end
            end
            WIN: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = MENU;
                    valid_d = 1'b0;
                    blink_d = 1'b0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
            end
            default: begin
                state_d = MENU;
                valid_d = 1'b0;
                blink_d = 1'b0;
            end
        endcase

        // Registered copy of "next state is MENU" keeps the finish-detector loop sequential.
        in_menu_d = (state_d == MENU);
    end

    assign is_in_menu    = in_menu_q;
    assign players_reset = preset_q;
    assign winner_valid  = valid_q;
    assign winner_id     = id_q;
    assign winner_blink  = blink_q;

endmodule

// File: tb/tb_race_screen_controller.sv
module tb_race_screen_controller;

    localparam int MAX_POS = 109;
    localparam int HOLD    = 20;
    localparam int BLINK   = 4;
    localparam int FIN     = MAX_POS - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       game_finished = 1'b0;
    logic [6:0] pos [4];
    logic       is_in_menu, players_reset, winner_valid, winner_blink;
    logic [1:0] winner_id;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    race_screen_controller #(
        .MAX_POS         (MAX_POS),
        .WIN_HOLD_CYCLES (HOLD),
        .BLINK_CYCLES    (BLINK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_btn      (start_btn),
        .game_finished  (game_finished),
        .green_cur_pos  (pos[0]),
        .red_cur_pos    (pos[1]),
        .blue_cur_pos   (pos[2]),
        .yellow_cur_pos (pos[3]),
        .is_in_menu     (is_in_menu),
        .players_reset  (players_reset),
        .winner_valid   (winner_valid),
        .winner_id      (winner_id),
        .winner_blink   (winner_blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: race phase flags plus the age of the win screen in cycles.
    bit m_playing = 0;
    bit m_winning = 0;
    int m_age     = 0;
    int m_winner  = 0;
    bit m_preset  = 0;
    bit m_prev    = 0;
    bit m_rise;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_playing = 0;
            m_winning = 0;
            m_age     = 0;
            m_winner  = 0;
            m_preset  = 0;
            m_prev    = 0;
        end else begin
            m_rise   = start_btn && !m_prev;
            m_preset = 0;
            if (m_winning) begin
                m_age++;
                if (m_age == HOLD) m_winning = 0;
            end else if (m_playing) begin
                if (game_finished) begin
                    m_playing = 0;
                    m_winning = 1;
                    m_age     = 0;
                    m_winner  = 0;
                    for (int i = 3; i >= 0; i--)
                        if (int'(pos[i]) == FIN) m_winner = i;
                end
            end else if (m_rise) begin
                m_playing = 1;
                m_preset  = 1;
            end
            m_prev = start_btn;
        end
    end

    always @(negedge clk) begin
        chk("model_in_menu", {31'd0, is_in_menu}, {31'd0, !(m_playing || m_winning)});
        chk("model_players_reset", {31'd0, players_reset}, {31'd0, m_preset});
        chk("model_winner_valid", {31'd0, winner_valid}, {31'd0, m_winning});
        chk("model_winner_id", {30'd0, winner_id}, m_winner);
        chk("model_winner_blink", {31'd0, winner_blink},
            {31'd0, m_winning && (((m_age / BLINK) % 2) == 0)});
    end

    task automatic set_pos(input int g, input int r, input int b, input int y);
        pos[0] = 7'(g);
        pos[1] = 7'(r);
        pos[2] = 7'(b);
        pos[3] = 7'(y);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_menu"}, {31'd0, is_in_menu}, 1);
        chk({tag, "_players_reset"}, {31'd0, players_reset}, 0);
        chk({tag, "_winner_valid"}, {31'd0, winner_valid}, 0);
        chk({tag, "_winner_id"}, {30'd0, winner_id}, 0);
        chk({tag, "_winner_blink"}, {31'd0, winner_blink}, 0);
    endtask

    initial begin
        set_pos(0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");

        rst_n = 1'b1;
        game_finished = 1'b1;
        repeat (3) @(negedge clk);
        chk("menu_ignores_finish", {31'd0, is_in_menu}, 1);
        game_finished = 1'b0;

        start_btn = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (players_reset) pulses++;
            if (k == 1) begin
                chk("start_pulse", {31'd0, players_reset}, 1);
                chk("start_leaves_menu", {31'd0, is_in_menu}, 0);
            end
        end
        chk("start_single_pulse", pulses, 1);

        start_btn = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        chk("play_ignores_start_reset", {31'd0, players_reset}, 0);
        chk("play_ignores_start_menu", {31'd0, is_in_menu}, 0);
        start_btn = 1'b0;

        set_pos(10, 20, FIN, 30);
        game_finished = 1'b1;
        @(negedge clk);
        game_finished = 1'b0;
        chk("blue_win_valid", {31'd0, winner_valid}, 1);
        chk("blue_win_id", {30'd0, winner_id}, 2);
        chk("blue_win_blink", {31'd0, winner_blink}, 1);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (players_reset) pulses++;
            if (k == 4)  chk("blink_off_at_4", {31'd0, winner_blink}, 0);
            if (k == 8)  chk("blink_on_at_8", {31'd0, winner_blink}, 1);
            if (k == 19) chk("win_held_at_19", {31'd0, winner_valid}, 1);
            if (k == 20) begin
                chk("win_exit_valid", {31'd0, winner_valid}, 0);
                chk("win_exit_menu", {31'd0, is_in_menu}, 1);
            end
            if (k == 2) set_pos(FIN, FIN, FIN, FIN);
            if (k == 3) start_btn = 1'b1;
            if (k == 5) game_finished = 1'b1;
            if (k == 6) begin
                game_finished = 1'b0;
                start_btn = 1'b0;
            end
        end
        chk("win_no_players_reset", pulses, 0);

        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        set_pos(0, FIN, 50, FIN);
        game_finished = 1'b1;
        @(negedge clk);
        game_finished = 1'b0;
        chk("tie_red_wins", {30'd0, winner_id}, 1);
        set_pos(FIN, 3, FIN, 7);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) chk("win_id_stable", {30'd0, winner_id}, 1);
        end
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_reset_needs_start", {31'd0, is_in_menu}, 1);
        start_btn = 1'b1;
        @(negedge clk);
        chk("restart_pulse", {31'd0, players_reset}, 1);
        chk("restart_menu", {31'd0, is_in_menu}, 0);
        start_btn = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
            game_finished = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 4; i++)
                pos[i] = ($urandom_range(0, 3) == 0) ? 7'(FIN) : 7'($urandom_range(0, FIN - 1));
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/race_screen_controller.md
Name: race_screen_controller

Overview:
- Top-level screen sequencer for the LED racer.
- Owns the MENU -> PLAYING -> WIN -> MENU flow and drives `is_in_menu` to the finish detector. It consumes that detector's `game_finished` flag and the four player positions.
- Latches the winner, runs the win-screen hold timer and blink timer, and issues a one-cycle reset pulse to the player position counters on game start.

Parameters:
- MAX_POS, 109, track length in LEDs; the finish position is MAX_POS-1.
- WIN_HOLD_CYCLES, 150000000, clock cycles the win screen is shown before returning to the menu.
- BLINK_CYCLES, 12500000, clock cycles per blink half-period on the win screen.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_btn  input  1  start button, already synchronised and debounced, level
- game_finished  input  1  from finish detector; high when any player is at MAX_POS-1 outside the menu
- green_cur_pos  input  $clog2(MAX_POS)  green player position
- red_cur_pos  input  $clog2(MAX_POS)  red player position
- blue_cur_pos  input  $clog2(MAX_POS)  blue player position
- yellow_cur_pos  input  $clog2(MAX_POS)  yellow player position
- is_in_menu  output  1  high while in MENU; registered
- players_reset  output  1  one-cycle pulse that clears all position counters
- winner_valid  output  1  high in WIN
- winner_id  output  2  0=green, 1=red, 2=blue, 3=yellow; valid when winner_valid=1
- winner_blink  output  1  blink phase for winner LEDs; 0 outside WIN

Behaviour:

Clock and reset:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- All flops are cleared on rst_n=0 regardless of clk.

Reset values:
- State = MENU.
- is_in_menu=1, players_reset=0, winner_valid=0, winner_id=0, winner_blink=0.
- Hold and blink counters = 0; start_btn edge register = 0.

Start edge:
- start_rise = start_btn & ~start_btn_q. start_btn_q is registered every cycle.
- Only rising edges act. A held button never retriggers.

State MENU:
- On start_rise, go to PLAYING next cycle. In the same edge, players_reset is registered to 1 for exactly one cycle. is_in_menu falls together with the state change.
- game_finished is ignored.

State PLAYING:
- start_rise is ignored.
- game_finished=1 at a clock edge -> WIN. In that same edge:
  - winner_id is latched by fixed priority green>red>blue>yellow among players whose cur_pos == MAX_POS-1. Simultaneous arrivals resolve by this priority.
  - If no position matches (inconsistent input), winner_id=0.
  - winner_valid<=1, hold counter<=0, blink counter<=0, winner_blink<=1.

State WIN:
- Hold counter increments each cycle.
- When it reaches WIN_HOLD_CYCLES-1, the next edge goes to MENU: winner_valid<=0, winner_blink<=0, is_in_menu<=1. winner_id keeps its last value.
- Blink counter counts 0..BLINK_CYCLES-1 and wraps. winner_blink toggles on each wrap.
- start_rise and game_finished are ignored.
- Position inputs are not re-sampled; winner_id is stable.

Latency:
- From start_rise to is_in_menu=0: 1 cycle.
- From game_finished=1 to winner_valid=1: 1 cycle.
- From win entry to MENU: exactly WIN_HOLD_CYCLES cycles.

Counter widths:
- Hold counter: $clog2(WIN_HOLD_CYCLES).
- Blink counter: $clog2(BLINK_CYCLES).
- Both are compared with equality, never with overflow.

Feedback loop:
- is_in_menu is registered, so the loop through the combinational finish detector is not a combinational loop.

Illegal state encoding:
- Recovers to MENU on the next edge.

Reset mid-operation:
- Immediate return to reset values from any state. No players_reset pulse is generated by reset itself.

Decomposition:
- Shared package race_pkg:
  - state enum (MENU, PLAYING, WIN);
  - player id constants (PLAYER_GREEN=0, PLAYER_RED=1, PLAYER_BLUE=2, PLAYER_YELLOW=3);
  - a function for position width $clog2(MAX_POS).
- One natural sub-module: winner_select, a combinational priority encoder mapping four positions plus MAX_POS to a 2-bit id.
- Timers stay inline in the FSM.

Test Plan:
All scenarios use MAX_POS=109, WIN_HOLD_CYCLES=20, BLINK_CYCLES=4.
- Reset then idle:
  - rst_n low 3 cycles -> is_in_menu=1, all other outputs 0.
  - With game_finished forced to 1 in MENU, state stays MENU.
- Start:
  - start_btn 0->1, held 10 cycles -> players_reset=1 for exactly one cycle, is_in_menu=0 from the next cycle.
  - No second pulse while held.
- Single winner:
  - In PLAYING, blue_cur_pos=108 with game_finished=1 -> next cycle winner_valid=1, winner_id=2, winner_blink=1.
  - winner_blink toggles every 4 cycles.
  - After 20 cycles in WIN, is_in_menu=1 and winner_valid=0.
- Simultaneous finish:
  - red_cur_pos=108 and yellow_cur_pos=108 in the same cycle -> winner_id=1.
  - Changing positions during WIN leaves winner_id=1.
- Ignored inputs:
  - start_rise during PLAYING and WIN -> no players_reset and no state change.
  - game_finished pulse in WIN -> hold count not restarted; exit still at cycle 20.
- Asynchronous reset mid-WIN:
  - rst_n low between clock edges at WIN cycle 7 -> outputs return to reset values before the next clk edge.
  - After release, start_rise is required to play again.
